// File: rtl/aes_mask_pkg.sv
// Shared definitions for the masked AES byte-serial datapath:
// FSM encoding, byte-index width and share layout helpers.
package aes_mask_pkg;

    localparam int BYTE_IDX_W = 4;
    localparam int NUM_BYTES  = 16;
    localparam int STATE_W    = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sb_state_e;

    // Position of (share, byte, bit) in a share-concatenated state vector.
    function automatic int state_bit(input int share, input int byte_idx, input int bit_idx);
        return share * STATE_W + 8 * byte_idx + bit_idx;
    endfunction

    // Position of (share, bit) in a bit-interleaved sbox lane.
    function automatic int lane_bit(input int num_shares, input int share, input int bit_idx);
        return bit_idx * num_shares + share;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Tracks which cycles carried a live byte into the pipelined sbox, so the
// matching result can be picked up exactly SBOX_LAT cycles later.
module valid_delay_line #(
    parameter int SBOX_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SBOX_LAT-1:0] pipe_q;
    logic [SBOX_LAT-1:0] pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = din;
        for (int j = 1; j < SBOX_LAT; j++) begin
            pipe_d[j] = pipe_q[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[SBOX_LAT-1];

endmodule

// File: rtl/aes_subbytes_serial.sv
// Byte-serial masked SubBytes(state ^ key): streams 16 bytes through an external
// pipelined masked sbox and collects the results back into the state register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for in_valid; only state where in_ready is high
// ST_FEED  | issuing byte issue_cnt to the sbox, rnd_en high
// ST_DRAIN | all bytes issued, waiting for the last sbox results
// ST_DONE  | state_out holds the substituted state until out_ready
module aes_subbytes_serial
    import aes_mask_pkg::*;
#(
    parameter int d        = 2,
    parameter int SBOX_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [128*d-1:0]     state_in,
    input  logic [128*d-1:0]     key_in,
    output logic [8*d-1:0]       sbox_in,
    input  logic [8*d-1:0]       sbox_out,
    output logic                 rnd_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [128*d-1:0]     state_out
);

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NUM_BYTES - 1);
    localparam logic [BYTE_IDX_W-1:0] CNT_ONE   = BYTE_IDX_W'(1);

    sb_state_e               state_q, state_d;
    logic [BYTE_IDX_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [BYTE_IDX_W-1:0]   collect_cnt_q, collect_cnt_d;
    logic [128*d-1:0]        data_q, data_d;
    logic                    in_ready_q, in_ready_d;
    logic                    rnd_en_q, rnd_en_d;
    logic                    out_valid_q, out_valid_d;
    logic                    collect;

    valid_delay_line #(.SBOX_LAT(SBOX_LAT)) u_valid_dl (
        .clk  (clk),
        .rst  (rst),
        .din  (rnd_en_q),
        .dout (collect)
    );

    // Results are written back in place: byte b is always collected after it
    // was issued, so one register holds both the operand and the result.
    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        collect_cnt_d = collect_cnt_q;
        data_d        = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d        = state_in ^ key_in;
                    issue_cnt_d   = '0;
                    collect_cnt_d = '0;
                    state_d       = ST_FEED;
                end
            end
            ST_FEED: begin
                if (issue_cnt_q == LAST_BYTE) begin
                    state_d = ST_DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d       = ST_IDLE;
                    issue_cnt_d   = '0;
                    collect_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (collect) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (collect_cnt_q == BYTE_IDX_W'(b)) begin
                    for (int i = 0; i < d; i++) begin
                        for (int k = 0; k < 8; k++) begin
                            data_d[state_bit(i, b, k)] = sbox_out[lane_bit(d, i, k)];
                        end
                    end
                end
            end
            if (collect_cnt_q == LAST_BYTE) begin
                state_d = ST_DONE;
            end else begin
                collect_cnt_d = collect_cnt_q + CNT_ONE;
            end
        end

        in_ready_d  = (state_d == ST_IDLE);
        rnd_en_d    = (state_d == ST_FEED);
        out_valid_d = (state_d == ST_DONE);
    end

    always_comb begin
        sbox_in = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (rnd_en_q && (issue_cnt_q == BYTE_IDX_W'(b))) begin
                for (int i = 0; i < d; i++) begin
                    for (int k = 0; k < 8; k++) begin
                        sbox_in[lane_bit(d, i, k)] = data_q[state_bit(i, b, k)];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            issue_cnt_q   <= '0;
            collect_cnt_q <= '0;
            data_q        <= '0;
            in_ready_q    <= 1'b1;
            rnd_en_q      <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            collect_cnt_q <= collect_cnt_d;
            data_q        <= data_d;
            in_ready_q    <= in_ready_d;
            rnd_en_q      <= rnd_en_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rnd_en    = rnd_en_q;
    assign out_valid = out_valid_q;
    assign state_out = data_q;

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Directed bench for aes_subbytes_serial (d=2, SBOX_LAT=2) with a behavioural
// two-stage masked sbox that re-masks every result with a fresh random share.
module tb_aes_subbytes_serial;

    localparam int D   = 2;
    localparam int LAT = 2;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] ALL_00    = '0;
    localparam logic [127:0] ALL_63    = {16{8'h63}};
    localparam logic [127:0] ALL_53    = {16{8'h53}};
    localparam logic [127:0] ALL_ED    = {16{8'hED}};
    localparam logic [127:0] PT_COUNT  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT_OFFSET = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] KEY_10    = {16{8'h10}};
    localparam logic [127:0] EXP_ROW0  = 128'h76abd7fe2b670130c56f6bf27b777c63;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [128*D-1:0] state_in;
    logic [128*D-1:0] key_in;
    logic [8*D-1:0]   sbox_in;
    logic [8*D-1:0]   sbox_out;
    logic             rnd_en;
    logic             out_valid;
    logic             out_ready;
    logic [128*D-1:0] state_out;

    int n_checks = 0;
    int n_errors = 0;

    int             obs_lat;
    int             obs_rnd;
    int             obs_nz;
    int             obs_first;
    int             obs_last;
    logic [127:0]   obs_issue;
    logic [255:0]   obs_out;

    aes_subbytes_serial #(.d(D), .SBOX_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .key_in    (key_in),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .rnd_en    (rnd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural masked sbox: recombine, substitute, re-share, two-cycle latency.
    logic [15:0] sb_p1 = '0;
    logic [15:0] sb_p2 = '0;
    assign sbox_out = sb_p2;

    always @(posedge clk) begin : sbox_model
        logic [7:0]  x;
        logic [7:0]  s;
        logic [7:0]  r;
        logic [15:0] pn;
        for (int k = 0; k < 8; k++) x[k] = sbox_in[2*k] ^ sbox_in[2*k+1];
        s = SBOX[x];
        r = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            pn[2*k]   = s[k] ^ r[k];
            pn[2*k+1] = r[k];
        end
        sb_p1 <= pn;
        sb_p2 <= sb_p1;
    end

    function automatic logic [255:0] mask_it(input logic [127:0] plain);
        logic [127:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        return {m, plain ^ m};
    endfunction

    function automatic logic [127:0] unmask(input logic [255:0] v);
        return v[127:0] ^ v[255:128];
    endfunction

    function automatic logic [7:0] lane_recomb(input logic [15:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[2*k] ^ v[2*k+1];
        return r;
    endfunction

    // Starts one operation from IDLE and observes it until out_valid; leaves the DUT in DONE.
    task automatic run_op(input logic [255:0] st, input logic [255:0] ky);
        in_valid  = 1'b1;
        state_in  = st;
        key_in    = ky;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        obs_lat   = -1;
        obs_rnd   = 0;
        obs_nz    = 0;
        obs_first = -1;
        obs_last  = -1;
        obs_issue = '0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (rnd_en) begin
                if (obs_first < 0) obs_first = cyc;
                obs_last = cyc;
                if (obs_rnd < 16) obs_issue[8*obs_rnd +: 8] = lane_recomb(sbox_in);
                obs_rnd++;
            end else if (sbox_in != '0) begin
                obs_nz++;
            end
            if (out_valid) begin
                obs_lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        obs_out = state_out;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (rnd_en !== 1'b0) begin n_errors++; $display("FAIL reset_rnd_en: got %b want 0", rnd_en); end
        n_checks++;
        if (sbox_in !== 16'h0) begin n_errors++; $display("FAIL reset_sbox_in: got %h want 0000", sbox_in); end
        n_checks++;
        if (state_out !== 256'h0) begin n_errors++; $display("FAIL reset_state_out: got %h want 0", state_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_key();
        logic [255:0] st;
        st = mask_it(ALL_00);
        run_op(st, mask_it(ALL_00));
        n_checks++;
        if (st[255:128] !== st[127:0]) begin n_errors++; $display("FAIL zero_share_setup: got %h want %h", st[127:0], st[255:128]); end
        n_checks++;
        if (obs_lat !== 19) begin n_errors++; $display("FAIL zero_latency: got %0d want 19", obs_lat); end
        n_checks++;
        if (unmask(obs_out) !== ALL_63) begin n_errors++; $display("FAIL zero_result: got %h want %h", unmask(obs_out), ALL_63); end
        n_checks++;
        if (obs_first !== 1 || obs_last !== 16) begin n_errors++; $display("FAIL zero_issue_window: got %0d..%0d want 1..16", obs_first, obs_last); end
        n_checks++;
        if (obs_rnd !== 16) begin n_errors++; $display("FAIL zero_rnd_cycles: got %0d want 16", obs_rnd); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL zero_done_in_ready: got %b want 0", in_ready); end
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL zero_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_const_53();
        run_op(mask_it(ALL_53), mask_it(ALL_00));
        n_checks++;
        if (unmask(obs_out) !== ALL_ED) begin n_errors++; $display("FAIL c53_result: got %h want %h", unmask(obs_out), ALL_ED); end
        n_checks++;
        if (obs_issue !== ALL_53) begin n_errors++; $display("FAIL c53_issued: got %h want %h", obs_issue, ALL_53); end
        n_checks++;
        if (obs_nz !== 0) begin n_errors++; $display("FAIL c53_idle_sbox_in: got %0d nonzero cycles want 0", obs_nz); end
        release_out();
    endtask

    task automatic test_byte_order();
        run_op(mask_it(PT_COUNT), mask_it(ALL_00));
        n_checks++;
        if (obs_issue !== PT_COUNT) begin n_errors++; $display("FAIL order_issued: got %h want %h", obs_issue, PT_COUNT); end
        n_checks++;
        if (unmask(obs_out) !== EXP_ROW0) begin n_errors++; $display("FAIL order_result: got %h want %h", unmask(obs_out), EXP_ROW0); end
        release_out();
        run_op(mask_it(PT_OFFSET), mask_it(KEY_10));
        n_checks++;
        if (obs_issue !== PT_COUNT) begin n_errors++; $display("FAIL keymix_issued: got %h want %h", obs_issue, PT_COUNT); end
        n_checks++;
        if (unmask(obs_out) !== EXP_ROW0) begin n_errors++; $display("FAIL keymix_result: got %h want %h", unmask(obs_out), EXP_ROW0); end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [255:0] snap;
        int           unstable;
        int           ready_seen;
        run_op(mask_it(ALL_53), mask_it(ALL_00));
        snap       = state_out;
        unstable   = 0;
        ready_seen = 0;
        in_valid   = 1'b1;
        state_in   = mask_it(PT_COUNT);
        key_in     = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || state_out !== snap) unstable++;
            if (in_ready !== 1'b0) ready_seen++;
        end
        n_checks++;
        if (unstable !== 0) begin n_errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
        n_checks++;
        if (ready_seen !== 0) begin n_errors++; $display("FAIL bp_in_ready: got %0d ready cycles want 0", ready_seen); end
        n_checks++;
        if (unmask(snap) !== ALL_ED) begin n_errors++; $display("FAIL bp_result: got %h want %h", unmask(snap), ALL_ED); end
        in_valid = 1'b0;
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_midrun();
        int ov_seen;
        in_valid = 1'b1;
        state_in = mask_it(PT_COUNT);
        key_in   = mask_it(ALL_00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        n_checks++;
        if (rnd_en !== 1'b1 || lane_recomb(sbox_in) !== 8'h07) begin n_errors++; $display("FAIL mid_byte7: got rnd=%b byte=%h want rnd=1 byte=07", rnd_en, lane_recomb(sbox_in)); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || rnd_en !== 1'b0 || sbox_in !== 16'h0) begin
            n_errors++;
            $display("FAIL mid_after_rst: got ir=%b rnd=%b sbox_in=%h want ir=1 rnd=0 sbox_in=0000", in_ready, rnd_en, sbox_in);
        end
        ov_seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid !== 1'b0) ov_seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (ov_seen !== 0) begin n_errors++; $display("FAIL mid_no_out_valid: got %0d cycles want 0", ov_seen); end
        run_op(mask_it(PT_OFFSET), mask_it(KEY_10));
        n_checks++;
        if (obs_lat !== 19) begin n_errors++; $display("FAIL mid_rerun_latency: got %0d want 19", obs_lat); end
        n_checks++;
        if (unmask(obs_out) !== EXP_ROW0) begin n_errors++; $display("FAIL mid_rerun_result: got %h want %h", unmask(obs_out), EXP_ROW0); end
        release_out();
    endtask

    task automatic test_back_to_back();
        int acc;
        int rnd;
        int nz;
        int ov;
        int bad;
        acc = 0; rnd = 0; nz = 0; ov = 0; bad = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        state_in  = mask_it(ALL_53);
        key_in    = mask_it(ALL_00);
        for (int c = 0; c < 60; c++) begin
            if (in_ready && in_valid) acc++;
            if (rnd_en) rnd++;
            else if (sbox_in != '0) nz++;
            if (out_valid) begin
                ov++;
                if (unmask(state_out) !== ALL_ED) bad++;
            end
            if (c == 59) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_checks++;
        if (acc !== 3) begin n_errors++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
        n_checks++;
        if (rnd !== 48) begin n_errors++; $display("FAIL b2b_rnd_cycles: got %0d want 48", rnd); end
        n_checks++;
        if (nz !== 0) begin n_errors++; $display("FAIL b2b_idle_sbox_in: got %0d want 0", nz); end
        n_checks++;
        if (ov !== 3 || bad !== 0) begin n_errors++; $display("FAIL b2b_results: got %0d valid %0d wrong want 3 valid 0 wrong", ov, bad); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_final_idle: got %b want 1", in_ready); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        key_in    = '0;
        test_reset();
        test_zero_key();
        test_const_53();
        test_byte_order();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_subbytes_serial.md
AES_SUBBYTES_SERIAL -- requirements
Module: aes_subbytes_serial

Interface
REQ-001 Parameter: d, default 2, number of Boolean shares per bit.
REQ-002 Parameter: SBOX_LAT, default 2, cycles from sbox_in to the matching sbox_out of the pipelined masked sbox.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  state_in/key_in valid.
REQ-006 in_ready  output  1  block idle, accepts a new state.
REQ-007 state_in  input  128*d  masked state; bit [i*128+8*b+k] = share i, byte b, bit k.
REQ-008 key_in  input  128*d  masked round key, same layout as state_in.
REQ-009 sbox_in  output  8*d  byte to masked sbox, bit-interleaved: bit [k*d+i] = share i, bit k.
REQ-010 sbox_out  input  8*d  masked sbox result, same interleaving as sbox_in.
REQ-011 rnd_en  output  1  high in cycles where sbox_in carries a live byte; gates the upstream PRNG.
REQ-012 out_valid  output  1  state_out holds 16 substituted bytes.
REQ-013 out_ready  input  1  consumer accepts state_out.
REQ-014 state_out  output  128*d  masked SubBytes(state ^ key); layout as state_in.

Function
REQ-015 The FSM SHALL have states IDLE, FEED, DRAIN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 When in_valid&in_ready, the block SHALL register state_in^key_in share-wise (no cross-share mixing) and go to FEED.
REQ-017 In FEED, one byte per cycle SHALL be driven on sbox_in in order b=0..15 from a 4-bit issue counter, with rnd_en=1.
REQ-018 After byte 15 is issued, the FSM SHALL go to DRAIN.
REQ-019 Outside FEED, sbox_in SHALL be all-zero and rnd_en SHALL be 0.
REQ-020 A SBOX_LAT-deep valid shift register SHALL track issued bytes; when its tail is 1, sbox_out SHALL be stored into byte slot [collect counter], then the counter increments.
REQ-021 Feed and collect SHALL overlap; when the 16th byte is stored, the FSM SHALL enter DONE with out_valid=1.
REQ-022 Latency: acceptance at edge T -> byte 0 on sbox_in in cycle T+1, byte 15 in T+16, out_valid asserted in cycle T+17+SBOX_LAT.
REQ-023 In DONE, state_out and out_valid SHALL hold stable until out_ready=1; the block SHALL then return to IDLE with out_valid=0 on the next edge.
REQ-024 in_valid outside IDLE SHALL be ignored; no input is buffered.
REQ-025 Counters SHALL not wrap within one state; the issue counter SHALL stop at 15 and the collect counter SHALL clear on entry to IDLE.
REQ-026 The block SHALL never combine shares; every register SHALL hold share-separated data.

Reset
REQ-027 On rst=1 at an edge: FSM->IDLE, counters and valid shift register=0, in_ready=1, out_valid=0, rnd_en=0, sbox_in=0.
REQ-028 state_out SHALL reset to 0.
REQ-029 Reset during FEED or DRAIN SHALL abandon the operation; late sbox_out values SHALL be discarded and SHALL not be captured.

Structure
REQ-030 Shared package aes_mask_pkg SHALL hold the FSM state enum, the byte-index width (4), and the share layout/interleave helper functions.
REQ-031 One sub-module, valid_delay_line (parameter SBOX_LAT, ports clk, rst, din, dout), SHALL implement the issue-tracking shift register.

Verification (d=2, SBOX_LAT=2; a bench model recombines shares and applies the unmasked AES sbox)
REQ-032 Unmasked state and key all 0x00, share1 = random mask M, share0 = M -> recombined state_out all 0x63; out_valid first high in cycle T+19.
REQ-033 Recombined state bytes 0x53, key 0x00, random masks -> every recombined output byte 0xED; byte order 0..15 preserved for a counting pattern 0x00..0x0F.
REQ-034 out_ready low for 5 cycles in DONE -> state_out and out_valid stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-035 rst pulsed in the cycle byte 7 is on sbox_in -> next cycle in_ready=1, sbox_in=0, rnd_en=0; no out_valid; a following run gives correct results.
REQ-036 in_valid held high throughout -> exactly one acceptance per IDLE visit; rnd_en high exactly 16 cycles per run; sbox_in zero whenever rnd_en=0.
